// File: rtl/wb_bram_arbiter.sv
// rtl/wb_bram_arbiter.sv - two-master Wishbone arbiter in front of a single-port BRAM
module wb_bram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DELAYS    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_adr_i,
    input  logic [31:0]       m0_dat_i,
    output logic [31:0]       m0_dat_o,
    output logic              m0_ack_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    output logic [31:0]       m1_dat_o,
    output logic              m1_ack_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam int CNT_W  = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam int LOCK_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DELAYS - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                gnt_q;         // master owning the beat in flight (1 = m1)
    logic                we_q;
    logic                abort_q;       // granted master dropped cyc during this beat
    logic                last_grant_q;  // master granted most recently (1 = m1)
    logic                lock_vld_q;    // last granted master still holds cyc
    logic [LOCK_W-1:0]   lock_cnt_q;    // beats completed by the current owner

    logic        req0, req1;
    logic        owner_cyc, gnt_cyc, owner_held;
    logic        win_d, win_we_d;
    logic [3:0]  win_sel_d;
    logic [31:0] win_adr_d, win_dat_d;
    logic        unused_adr;

    // Winner selection: a held owner keeps the bus on a tie, otherwise round-robin
    always_comb begin
        req0       = m0_cyc_i & m0_stb_i;
        req1       = m1_cyc_i & m1_stb_i;
        owner_cyc  = last_grant_q ? m1_cyc_i : m0_cyc_i;
        gnt_cyc    = gnt_q ? m1_cyc_i : m0_cyc_i;
        owner_held = lock_vld_q & owner_cyc & (lock_cnt_q < LOCK_MAX);
        if (req0 & req1) begin
            win_d = owner_held ? last_grant_q : ~last_grant_q;
        end else begin
            win_d = req1;
        end
        win_we_d  = win_d ? m1_we_i  : m0_we_i;
        win_sel_d = win_d ? m1_sel_i : m0_sel_i;
        win_adr_d = win_d ? m1_adr_i : m0_adr_i;
        win_dat_d = win_d ? m1_dat_i : m0_dat_i;
    end

    // Byte-lane bits and the upper window bits never reach the BRAM
    assign unused_adr = ^{win_adr_d[31:ADDR_W+2], win_adr_d[1:0]};

    // Arbitration FSM, lock bookkeeping and all registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_vld_q   <= 1'b0;
            lock_cnt_q   <= '0;
            m0_dat_o     <= '0;
            m1_dat_o     <= '0;
            m0_ack_o     <= 1'b0;
            m1_ack_o     <= 1'b0;
            ram_en_o     <= 1'b0;
            ram_we_o     <= '0;
            ram_adr_o    <= '0;
            ram_dat_o    <= '0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
        end else begin
            // Owner releasing cyc ends its lock; a grant below may re-arm it
            if (lock_vld_q && !owner_cyc) begin
                lock_vld_q <= 1'b0;
                lock_cnt_q <= '0;
            end
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            ram_we_o <= '0;

            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q      <= ACCESS;
                        cnt_q        <= '0;
                        gnt_q        <= win_d;
                        we_q         <= win_we_d;
                        abort_q      <= 1'b0;
                        grant_o      <= win_d ? 2'b10 : 2'b01;
                        busy_o       <= 1'b1;
                        ram_en_o     <= 1'b1;
                        ram_adr_o    <= win_adr_d[ADDR_W+1:2];
                        ram_dat_o    <= win_dat_d;
                        ram_we_o     <= win_we_d ? win_sel_d : 4'b0000;
                        last_grant_q <= win_d;
                        lock_vld_q   <= 1'b1;
                        if (win_d != last_grant_q) begin
                            lock_cnt_q <= '0;
                        end
                    end
                end

                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!gnt_cyc) begin
                        abort_q <= 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        ram_en_o <= 1'b0;
                        if (abort_q || !gnt_cyc) begin
                            // Aborted beat: RAM side finished, no ack, lock released
                            state_q    <= IDLE;
                            grant_o    <= '0;
                            busy_o     <= 1'b0;
                            lock_vld_q <= 1'b0;
                            lock_cnt_q <= '0;
                        end else begin
                            state_q <= ACK;
                            if (gnt_q) begin
                                m1_ack_o <= 1'b1;
                                if (!we_q) m1_dat_o <= ram_dat_i;
                            end else begin
                                m0_ack_o <= 1'b1;
                                if (!we_q) m0_dat_o <= ram_dat_i;
                            end
                        end
                    end
                end

                ACK: begin
                    state_q <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    if (owner_cyc && lock_cnt_q != LOCK_MAX) begin
                        lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb/tb_wb_bram_arbiter.sv - directed self-checking bench for wb_bram_arbiter
module tb_wb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [9:0]  ram_adr_o;
    logic [31:0] ram_dat_o;
    logic [31:0] ram_dat_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    logic [31:0] mem [1024];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_adr = '0;
    logic [31:0] pre_dat = '0;

    int n_chk = 0;
    int n_err = 0;
    int ack_log [$];
    int we_cnt;

    wb_bram_arbiter #(.ADDR_W(10), .DELAYS(10), .MAX_BURST(4)) dut (
        .wb_clk_i(clk),        .wb_rst_i(rst),
        .m0_cyc_i(m_cyc[0]),   .m0_stb_i(m_stb[0]),  .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]),   .m0_adr_i(m_adr[0]),  .m0_dat_i(m_dat[0]),
        .m0_dat_o(m0_dat_o),   .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m_cyc[1]),   .m1_stb_i(m_stb[1]),  .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]),   .m1_adr_i(m_adr[1]),  .m1_dat_i(m_dat[1]),
        .m1_dat_o(m1_dat_o),   .m1_ack_o(m1_ack_o),
        .ram_en_o(ram_en_o),   .ram_we_o(ram_we_o),  .ram_adr_o(ram_adr_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
        .grant_o(grant_o),     .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // BRAM model: byte-lane writes on the clock, combinational read
    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) mem[ram_adr_o][8*b +: 8] <= ram_dat_o[8*b +: 8];
        end
    end
    assign ram_dat_i = mem[ram_adr_o];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Every ack: never both, and always to the granted master
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o) begin
            chk("dual_ack", 32'(m0_ack_o & m1_ack_o), 32'd0);
            chk("ack_grant", 32'(grant_o), 32'({m1_ack_o, m0_ack_o}));
            ack_log.push_back(m1_ack_o ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic ram_put(input int word, input logic [31:0] dat);
        pre_adr = 10'(word);
        pre_dat = dat;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack0"}, 32'(m0_ack_o), 32'd0);
        chk({tag, "_ack1"}, 32'(m1_ack_o), 32'd0);
        chk({tag, "_dat0"}, m0_dat_o, 32'd0);
        chk({tag, "_dat1"}, m1_dat_o, 32'd0);
        chk({tag, "_en"}, 32'(ram_en_o), 32'd0);
        chk({tag, "_we"}, 32'(ram_we_o), 32'd0);
        chk({tag, "_adr"}, 32'(ram_adr_o), 32'd0);
        chk({tag, "_rdat"}, ram_dat_o, 32'd0);
        chk({tag, "_grant"}, 32'(grant_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic chk_log(input string tag, input logic [15:0] seq, input int n);
        chk({tag, "_len"}, 32'(ack_log.size()), 32'(n));
        for (int i = 0; i < n && i < ack_log.size(); i++)
            chk(tag, 32'(ack_log[i]), 32'(seq[i]));
        ack_log.delete();
    endtask

    task automatic wb_beat(input int m, input int word, input logic we,
                           input logic [31:0] dat, input bit keep);
        int n = 0;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_sel[m] = 4'hF;
        m_adr[m] = 32'h3800_0000 + 32'(word * 4); m_dat[m] = dat;
        do begin
            @(negedge clk);
            n++;
        end while (!(m == 1 ? m1_ack_o : m0_ack_o) && n < 200);
        chk("beat_done", 32'(n < 200), 32'd1);
        if (!keep) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic idle_masters();
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_sel[m] = 4'h0; m_adr[m] = '0;   m_dat[m] = '0;
        end
    endtask

    initial begin
        idle_masters();
        ram_put(4, 32'h1234_5678);
        ram_put(2, 32'hAAAA_AAAA);
        ram_put(6, 32'hCAFE_F00D);
        @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Tie right after reset, cyc toggled between beats: m0, m1, m0, m1
        ack_log.delete();
        fork
            begin wb_beat(0, 32, 1'b1, 32'h0000_0A00, 1'b0); wb_beat(0, 33, 1'b1, 32'h0000_0A01, 1'b0); end
            begin wb_beat(1, 40, 1'b1, 32'h0000_0B00, 1'b0); wb_beat(1, 41, 1'b1, 32'h0000_0B01, 1'b0); end
        join
        chk_log("alt_order", 16'h000A, 4);

        // m0 single read of word 4
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_adr[0] = 32'h3800_0010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("rd_adr", 32'(ram_adr_o), 32'd4);
            chk("rd_en", 32'(ram_en_o), 32'd1);
            chk("rd_ack_early", 32'(m0_ack_o), 32'd0);
            if (k == 1) chk("rd_grant", 32'(grant_o), 32'd1);
        end
        @(negedge clk);
        chk("rd_ack", 32'(m0_ack_o), 32'd1);
        chk("rd_dat", m0_dat_o, 32'h1234_5678);
        chk("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        chk("rd_ack_one", 32'(m0_ack_o), 32'd0);
        chk("rd_busy_off", 32'(busy_o), 32'd0);
        chk("rd_grant_off", 32'(grant_o), 32'd0);

        // m1 byte-masked write of word 2
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'b0011;
        m_adr[1] = 32'h3800_0008; m_dat[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_we", 32'(ram_we_o), 32'h3);
        chk("wr_adr", 32'(ram_adr_o), 32'd2);
        chk("wr_dat", ram_dat_o, 32'hDEAD_BEEF);
        chk("wr_grant", 32'(grant_o), 32'd2);
        we_cnt = 1;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (ram_we_o != 4'b0) we_cnt++;
            chk("wr_ack_early", 32'(m1_ack_o), 32'd0);
        end
        @(negedge clk);
        chk("wr_ack", 32'(m1_ack_o), 32'd1);
        chk("wr_m0_ack", 32'(m0_ack_o), 32'd0);
        chk("wr_we_cycles", 32'(we_cnt), 32'd1);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        chk("wr_mem", mem[2], 32'hAAAA_BEEF);

        // m1 8-beat burst with m0 waiting from beat 1: 1,1,1,1,0,1,1,1,1
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    wb_beat(1, 16 + i, 1'b1, 32'(100 + i), i < 7);
            end
            begin repeat (3) @(negedge clk); wb_beat(0, 4, 1'b0, 32'h0, 1'b0); end
        join
        chk_log("burst_order", 16'h01EF, 9);
        chk("burst_mem_first", mem[16], 32'd100);
        chk("burst_mem_last", mem[23], 32'd107);
        chk("burst_m0_dat", m0_dat_o, 32'h1234_5678);

        // m0 drops cyc in ACCESS cycle 3 while m1 waits
        ack_log.delete();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h3800_0014;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h3800_0018;
        @(negedge clk);
        chk("abort_grant0", 32'(grant_o), 32'd1);
        repeat (3) @(negedge clk);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_idle_grant", 32'(grant_o), 32'd0);
        chk("abort_idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("abort_grant1", 32'(grant_o), 32'd2);
        repeat (9) @(negedge clk);
        chk("abort_m1_early", 32'(m1_ack_o), 32'd0);
        @(negedge clk);
        chk("abort_m1_ack", 32'(m1_ack_o), 32'd1);
        chk("abort_m1_dat", m1_dat_o, 32'hCAFE_F00D);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        chk_log("abort_order", 16'h0001, 1);

        // Reset pulse in ACCESS cycle 5, then a tie must go to m0
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h3800_0010;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_outputs_zero("rst_mid");
        repeat (15) @(negedge clk);
        chk_log("rst_no_ack", 16'h0000, 0);
        fork
            wb_beat(0, 4, 1'b0, 32'h0, 1'b0);
            wb_beat(1, 6, 1'b0, 32'h0, 1'b0);
        join
        chk_log("rst_tie_order", 16'h0002, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_bram_arbiter.md
# wb_bram_arbiter

Two-master Wishbone arbiter that shares the user-project BRAM (mprjram, 0x38000000) between the management CPU's Wishbone port and an accelerator DMA port (FIR/matmul engine). It serializes accesses to the single-port BRAM with a fixed access latency, round-robin arbitration and bounded burst locking. It sits inside the user project wrapper, between the wbs_* bus and the BRAM macro.

## Interface
Parameters:
- ADDR_W, 10, BRAM word-address width (1K words).
- DELAYS, 10, BRAM access cycles per beat (≥1).
- MAX_BURST, 4, max consecutive beats one master keeps while the other is waiting.

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_i  in  1  reset; synchronous, active-high.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  Wishbone classic controls, N ∈ {0,1} (m0 = CPU, m1 = DMA).
- mN_sel_i  in  4  byte selects.
- mN_adr_i  in  32  byte address; the upstream decoder has already selected the BRAM.
- mN_dat_i  in  32  write data.
- mN_dat_o  out  32  read data, registered.
- mN_ack_o  out  1  one-cycle acknowledge.
- ram_en_o  out  1  BRAM enable.
- ram_we_o  out  4  BRAM byte write enables.
- ram_adr_o  out  ADDR_W  word address.
- ram_dat_o  out  32  BRAM write data.
- ram_dat_i  in  32  BRAM read data.
- grant_o  out  2  one-hot owner of the current access; 0 when idle.
- busy_o  out  1  high in ACCESS or ACK.

## Operation
- Request: reqN = mN_cyc_i & mN_stb_i.
- FSM: IDLE → ACCESS → ACK → IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise latch the winner's adr, we, sel and dat, then go to ACCESS.
- Winner selection:
  - Single requester: it wins.
  - Both requesting, owner held (lock_cnt < MAX_BURST): the owner wins.
  - Both requesting, otherwise: the master that was not granted last wins. last_grant resets to m1, so m0 wins the first tie.
- Lock:
  - owner = last granted master while its cyc_i stays high.
  - lock_cnt increments per completed beat to the owner.
  - lock_cnt clears when the owner drops cyc_i or the other master is granted.
  - A lone requester is never limited by MAX_BURST.
- ACCESS (DELAYS cycles, counter 0..DELAYS-1):
  - ram_en_o = 1 throughout.
  - ram_adr_o = adr[ADDR_W+1:2]; upper address bits are ignored.
  - ram_dat_o = latched write data.
  - ram_we_o = sel if we, else 0. It is asserted only in counter cycle 0, so each write is exactly one cycle.
  - Reads: mN_dat_o captures ram_dat_i on the last ACCESS cycle.
- ACK (1 cycle):
  - Only the granted master's ack_o is high; mN_dat_o is held valid.
  - Next state is IDLE.
  - The other master's dat_o and ack_o are unchanged and 0 respectively.
- Abort: if the granted master's cyc_i falls during ACCESS:
  - The access completes on the RAM side; a write already issued stays written.
  - ack is suppressed, the FSM goes to IDLE and the lock clears.
- stb dropped during ACCESS with cyc high: ignored; the beat completes and is acked.
- Acks never go to an ungranted master, and both acks are never high together.

## Timing
- Reset values (the cycle after wb_rst_i is sampled high):
  - State IDLE, lock_cnt 0, last_grant = m1.
  - All outputs 0: mN_ack_o, mN_dat_o, ram_en_o, ram_we_o, ram_adr_o, ram_dat_o, grant_o, busy_o.
- Reset mid-ACCESS or mid-ACK: the pending ack is dropped and a write already issued is not undone.
- Beat latency: request first seen in IDLE at cycle t.
  - ACCESS occupies cycles t+1..t+DELAYS.
  - ack_o is high at cycle t+DELAYS+1.
  - IDLE is at t+DELAYS+2, where the next request may be granted.
  - Sustained throughput is one beat per DELAYS+2 cycles.
- Masters must deassert stb (or present a new beat) in the cycle after ack. A stb still high in IDLE is treated as a new request.
- grant_o and busy_o rise at t+1 and fall at t+DELAYS+2.

## Test plan
- m0 read, adr 0x3800_0010, RAM word 4 = 0x1234_5678, DELAYS=10, request at t → ram_adr_o = 4 during t+1..t+10; m0_ack_o high at t+11 only; m0_dat_o = 0x1234_5678; m1_ack_o stays 0.
- m1 write, adr 0x3800_0008, dat 0xDEAD_BEEF, sel 4'b0011 → ram_we_o = 0011 for exactly one cycle (t+1) with ram_adr_o = 2 and ram_dat_o = 0xDEAD_BEEF; m1_ack_o at t+11.
- Both masters assert single beats with cyc toggled off after each ack, starting right after reset → grants m0, m1, m0, m1; no two acks in one cycle.
- m1 holds cyc for an 8-beat burst, m0 requests from beat 1, MAX_BURST=4 → m1 gets beats 1-4, then m0 is served, then m1 resumes with beats 5-8.
- m0 drops cyc in ACCESS cycle 3 while m1 is requesting → no m0_ack_o, FSM returns to IDLE, m1 is granted the next IDLE cycle, and its ack arrives DELAYS+1 cycles later.
- wb_rst_i pulsed in ACCESS cycle 5 → next cycle all outputs 0 and grant_o = 0; no ack follows; then a simultaneous request pair grants m0 first.
